// File: rtl/lc_tx_array_filter.sv
// rtl/lc_tx_array_filter.sv - per-lane synchroniser, debounce and encoding filter for lc_tx_t arrays.
// Invalid committed encodings force the lane Off and raise a sticky, acknowledgeable alert.
module lc_tx_array_filter #(
  parameter int NUM_LANES     = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [4*NUM_LANES-1:0] lc_tx_i,
  input  logic                   alert_ack_i,
  output logic [4*NUM_LANES-1:0] lc_tx_o,
  output logic [NUM_LANES-1:0]   lane_on_o,
  output logic                   invalid_alert_o,
  output logic [NUM_LANES-1:0]   alert_lane_o,
  output logic [7:0]             error_count_o
);

  localparam logic [3:0] LC_ON      = 4'b1010;
  localparam logic [3:0] LC_OFF     = 4'b1111;
  localparam logic [3:0] CNT_COMMIT = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_SAT    = 4'(STABLE_CYCLES);

  logic [4*NUM_LANES-1:0]    s1_q, s2_q;
  logic [4*NUM_LANES-1:0]    cand_q, cand_d;
  logic [4*NUM_LANES-1:0]    out_q, out_d;
  logic [NUM_LANES-1:0][3:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0]      on_q, on_d;
  logic [NUM_LANES-1:0]      alert_q, alert_d;
  logic [NUM_LANES-1:0]      inv_commit;
  logic [7:0]                err_q, err_d;
  int unsigned               err_sum;

  always_comb begin
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    on_d       = on_q;
    inv_commit = '0;
    // Acknowledge clears first so a same-edge invalid commit below wins.
    alert_d    = alert_ack_i ? '0 : alert_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (s2_q[4*k +: 4] != cand_q[4*k +: 4]) begin
        cand_d[4*k +: 4] = s2_q[4*k +: 4];
        cnt_d[k]         = 4'd1;
      end else if (cnt_q[k] == CNT_COMMIT) begin
        cnt_d[k] = CNT_SAT;
        if (cand_q[4*k +: 4] == LC_ON || cand_q[4*k +: 4] == LC_OFF) begin
          out_d[4*k +: 4] = cand_q[4*k +: 4];
          on_d[k]         = (cand_q[4*k +: 4] == LC_ON);
        end else begin
          out_d[4*k +: 4] = LC_OFF;
          on_d[k]         = 1'b0;
          alert_d[k]      = 1'b1;
          inv_commit[k]   = 1'b1;
        end
      end else if (cnt_q[k] < CNT_COMMIT) begin
        cnt_d[k] = cnt_q[k] + 4'd1;
      end
    end
  end

  always_comb begin
    err_sum = 32'(err_q);
    for (int k = 0; k < NUM_LANES; k++) begin
      err_sum = err_sum + 32'(inv_commit[k]);
    end
    err_d = (err_sum > 32'd255) ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= {NUM_LANES{LC_OFF}};
      s2_q    <= {NUM_LANES{LC_OFF}};
      cand_q  <= {NUM_LANES{LC_OFF}};
      out_q   <= {NUM_LANES{LC_OFF}};
      cnt_q   <= '0;
      on_q    <= '0;
      alert_q <= '0;
      err_q   <= '0;
    end else begin
      s1_q    <= lc_tx_i;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      alert_q <= alert_d;
      err_q   <= err_d;
    end
  end

  assign lc_tx_o         = out_q;
  assign lane_on_o       = on_q;
  assign alert_lane_o    = alert_q;
  assign invalid_alert_o = |alert_q;
  assign error_count_o   = err_q;

endmodule

// File: tb/tb_lc_tx_array_filter.sv
// tb/tb_lc_tx_array_filter.sv - scoreboard bench for lc_tx_array_filter.
// Stimulus pushes the expected post-edge state; the monitor checks it just after that edge.
module tb_lc_tx_array_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lc_tx_i = 8'hff;
  logic       alert_ack_i = 1'b0;
  logic [7:0] lc_tx_o;
  logic [1:0] lane_on_o;
  logic       invalid_alert_o;
  logic [1:0] alert_lane_o;
  logic [7:0] error_count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] tx;
    logic [1:0] on;
    logic [1:0] al;
    logic [7:0] err;
    logic [2:0] m;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] ALL = 3'b111;
  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] ERR = 3'b100;

  lc_tx_array_filter #(.NUM_LANES(2), .STABLE_CYCLES(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lc_tx_i        (lc_tx_i),
    .alert_ack_i    (alert_ack_i),
    .lc_tx_o        (lc_tx_o),
    .lane_on_o      (lane_on_o),
    .invalid_alert_o(invalid_alert_o),
    .alert_lane_o   (alert_lane_o),
    .error_count_o  (error_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [7:0] tx, input logic ack, input logic [7:0] e_tx,
                     input logic [1:0] e_on, input logic [1:0] e_al, input logic [7:0] e_err,
                     input logic [2:0] m);
    exp_t e;
    @(negedge clk);
    lc_tx_i     = tx;
    alert_ack_i = ack;
    e.tx = e_tx; e.on = e_on; e.al = e_al; e.err = e_err; e.m = m;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[0]) begin
          chk("lc_tx_o", 32'(lc_tx_o), 32'(e.tx));
          chk("lane_on_o", 32'(lane_on_o), 32'(e.on));
        end
        if (e.m[1]) begin
          chk("alert_lane_o", 32'(alert_lane_o), 32'(e.al));
          chk("invalid_alert_o", 32'(invalid_alert_o), 32'(|e.al));
        end
        if (e.m[2]) chk("error_count_o", 32'(error_count_o), 32'(e.err));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] e_err;
    // Reset state, input already presenting lane1=On, lane0=Off.
    cyc(8'haf, 1'b0, 8'hff, 2'b00, 2'b00, 8'd0, ALL);
    cyc(8'haf, 1'b0, 8'hff, 2'b00, 2'b00, 8'd0, ALL);
    @(negedge clk);
    rst_n = 1'b1;
    // Edge 1 has no entry; edges 2..8 follow.
    repeat (3) cyc(8'haf, 1'b0, 8'hff, 2'b00, 2'b00, 8'd0, ALL);
    repeat (4) cyc(8'haf, 1'b0, 8'haf, 2'b10, 2'b00, 8'd0, ALL);

    // Two-sample On glitch on lane0 must not commit.
    repeat (2) cyc(8'haa, 1'b0, 8'haf, 2'b10, 2'b00, 8'd0, ALL);
    repeat (6) cyc(8'haf, 1'b0, 8'haf, 2'b10, 2'b00, 8'd0, ALL);

    // Invalid lane1 commits Off with alert, then acknowledge clears it.
    repeat (4) cyc(8'h0f, 1'b0, 8'haf, 2'b10, 2'b00, 8'd0, ALL);
    cyc(8'h0f, 1'b0, 8'hff, 2'b00, 2'b10, 8'd1, ALL);
    cyc(8'h0f, 1'b0, 8'hff, 2'b00, 2'b10, 8'd1, ALL);
    cyc(8'h0f, 1'b1, 8'hff, 2'b00, 2'b00, 8'd1, ALL);
    cyc(8'h0f, 1'b0, 8'hff, 2'b00, 2'b00, 8'd1, ALL);

    // Both lanes invalid; acknowledge on the commit edge loses to the set.
    repeat (4) cyc(8'h55, 1'b0, 8'hff, 2'b00, 2'b00, 8'd1, ALL);
    cyc(8'h55, 1'b1, 8'hff, 2'b00, 2'b11, 8'd3, ALL);
    cyc(8'h55, 1'b0, 8'hff, 2'b00, 2'b11, 8'd3, ALL);
    cyc(8'h55, 1'b1, 8'hff, 2'b00, 2'b00, 8'd3, ALL);

    // 300 invalid runs on lane0: counter saturates at 255.
    for (int p = 1; p <= 300; p++) begin
      e_err = (3 + p > 255) ? 8'd255 : 8'(3 + p);
      repeat (4) cyc(8'hf0, 1'b0, 8'h00, 2'b00, 2'b00, 8'd0, NONE);
      repeat (3) cyc(8'hff, 1'b0, 8'h00, 2'b00, 2'b00, 8'd0, NONE);
      cyc(8'hff, 1'b0, 8'h00, 2'b00, 2'b00, e_err, ERR);
    end

    // Reset mid-run of a valid On on lane0.
    repeat (3) cyc(8'hfa, 1'b0, 8'h00, 2'b00, 2'b00, 8'd0, NONE);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst lc_tx_o", 32'(lc_tx_o), 32'h ff);
    chk("async_rst lane_on_o", 32'(lane_on_o), 32'd0);
    chk("async_rst alert_lane_o", 32'(alert_lane_o), 32'd0);
    chk("async_rst invalid_alert_o", 32'(invalid_alert_o), 32'd0);
    chk("async_rst error_count_o", 32'(error_count_o), 32'd0);
    cyc(8'hfa, 1'b0, 8'hff, 2'b00, 2'b00, 8'd0, ALL);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc(8'hfa, 1'b0, 8'hff, 2'b00, 2'b00, 8'd0, ALL);
    repeat (2) cyc(8'hfa, 1'b0, 8'hfa, 2'b01, 2'b00, 8'd0, ALL);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
